// File: rtl/argmax_tree_stream_if.sv
// -----------------------------------------------------------------------------
// argmax_tree_stream_if
//
// Groups the beat-input and frame-result signals of argmax_tree_stream.
//
// Handshake: there is no backpressure. A beat is accepted on every rising clk
// edge where in_valid is high. in_last and find_min only mean something while
// in_valid is high. out_valid is a one-cycle pulse that qualifies out_data.
//
// Signals:
//   in_valid   beat valid
//   in_last    final beat of the current frame
//   find_min   0 = arg-max, 1 = arg-min; captured on the first beat of a frame
//   din        N_INPUTS lanes, lane k = din[k*W +: W], score in the low bits
//   out_valid  frame result pulse
//   out_data   winning lane word, held until the next out_valid
//   frame_open a frame has taken at least one beat but not yet its last one
//
// Modports:
//   master  upstream side: drives the beat, observes the result
//   slave   the reduction tree itself
// -----------------------------------------------------------------------------
interface argmax_tree_stream_if #(
   parameter int DATA_WIDTH = 16,
   parameter int INDX_WIDTH = 13,
   parameter int ADDR_WIDTH = 6,
   parameter int N_INPUTS   = 64
);
   localparam int W = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH;

   logic                  in_valid;
   logic                  in_last;
   logic                  find_min;
   logic [N_INPUTS*W-1:0] din;
   logic                  out_valid;
   logic [W-1:0]          out_data;
   logic                  frame_open;

   modport master (
      output in_valid, in_last, find_min, din,
      input  out_valid, out_data, frame_open
   );

   modport slave (
      input  in_valid, in_last, find_min, din,
      output out_valid, out_data, frame_open
   );
endinterface

// File: rtl/argmax_tree_stream.sv
// -----------------------------------------------------------------------------
// argmax_tree_stream
//
// Fully pipelined arg-max / arg-min reduction over framed beats. Each beat
// carries N_INPUTS tagged lanes. A binary tree of L = log2(N_INPUTS) register
// stages reduces one beat to one lane. A final accumulator stage folds the
// successive beats of a frame and emits the best lane of the whole frame when
// the beat marked last leaves the tree.
//
// Only the unsigned score field (low DATA_WIDTH bits) is compared. The index
// and address payload bits above it travel through unchanged.
//
// Ties: the left operand wins. Inside the tree the left operand is the
// lower-numbered lane. In the accumulator the left operand is the stored
// result of earlier beats. The earliest candidate therefore wins overall.
//
// Latency: a beat presented in cycle t (sampled at the end of t) reaches the
// accumulator output L+1 edges later. For N_INPUTS = 64 this is 7 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears the pipeline, the
//          accumulator, the result and the frame state
//   bus    argmax_tree_stream_if.slave (beat in, frame result out)
// -----------------------------------------------------------------------------
module argmax_tree_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int INDX_WIDTH = 13,
   parameter int ADDR_WIDTH = 6,
   parameter int N_INPUTS   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   argmax_tree_stream_if.slave  bus
);
   localparam int W  = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH;
   localparam int L  = $clog2(N_INPUTS);
   localparam int NT = N_INPUTS - 1;   // total tree register lanes over all stages

   // True when the left operand should be kept under the given mode.
   // Ties keep the left operand in both modes.
   function automatic logic keep_left(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b,
                                      input logic                  use_min);
      keep_left = use_min ? (a <= b) : (a >= b);
   endfunction

   // All tree stages live in one flat array. Stage s holds N_INPUTS >> (s+1)
   // lanes starting at this offset, so the last stage is the single entry NT-1.
   function automatic int stage_off(input int s);
      stage_off = N_INPUTS - (N_INPUTS >> s);
   endfunction

   // ---------------------------------------------------------------------------
   // Frame tracking and mode capture
   // ---------------------------------------------------------------------------
   logic frame_open_q;
   logic mode_q;
   logic beat_mode;

   // The first beat of a frame uses find_min directly. Later beats reuse the
   // captured value, so toggling find_min mid-frame has no effect.
   assign beat_mode = frame_open_q ? mode_q : bus.find_min;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_open_q <= 1'b0;
         mode_q       <= 1'b0;
      end else if (bus.in_valid) begin
         frame_open_q <= ~bus.in_last;
         if (!frame_open_q) begin
            mode_q <= bus.find_min;
         end
      end
   end

   assign bus.frame_open = frame_open_q;

   // ---------------------------------------------------------------------------
   // Reduction tree
   // ---------------------------------------------------------------------------
   logic [W-1:0] tree_q [0:NT-1];
   logic [W-1:0] tree_d [0:NT-1];
   logic [L-1:0] vld_q;   // per-stage {valid, last, mode} travelling with the beat
   logic [L-1:0] lst_q;
   logic [L-1:0] mod_q;

   logic [W-1:0] left_w;
   logic [W-1:0] right_w;

   always_comb begin
      for (int k = 0; k < NT; k++) begin
         tree_d[k] = '0;
      end
      left_w  = '0;
      right_w = '0;

      // Stage 0 reduces the input lanes using the beat's resolved mode.
      for (int j = 0; j < (N_INPUTS >> 1); j++) begin
         left_w  = bus.din[(2*j)*W +: W];
         right_w = bus.din[(2*j+1)*W +: W];
         tree_d[j] = keep_left(left_w[DATA_WIDTH-1:0], right_w[DATA_WIDTH-1:0], beat_mode)
                     ? left_w : right_w;
      end

      // Later stages reduce the previous stage using the mode carried with it.
      for (int s = 1; s < L; s++) begin
         for (int j = 0; j < (N_INPUTS >> (s + 1)); j++) begin
            left_w  = tree_q[stage_off(s - 1) + 2*j];
            right_w = tree_q[stage_off(s - 1) + 2*j + 1];
            tree_d[stage_off(s) + j] =
               keep_left(left_w[DATA_WIDTH-1:0], right_w[DATA_WIDTH-1:0], mod_q[s-1])
               ? left_w : right_w;
         end
      end
   end

   // Stage registers load every cycle. Invalid beats pass through as bubbles
   // and are ignored by the accumulator through vld_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NT; k++) begin
            tree_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NT; k++) begin
            tree_q[k] <= tree_d[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         lst_q <= '0;
         mod_q <= '0;
      end else begin
         vld_q[0] <= bus.in_valid;
         lst_q[0] <= bus.in_valid & bus.in_last;
         mod_q[0] <= beat_mode;
         for (int s = 1; s < L; s++) begin
            vld_q[s] <= vld_q[s-1];
            lst_q[s] <= lst_q[s-1];
            mod_q[s] <= mod_q[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame accumulator and result register
   // ---------------------------------------------------------------------------
   logic [W-1:0] tail;
   logic         tail_vld;
   logic         tail_lst;
   logic         tail_mode;
   logic [W-1:0] acc_q;
   logic         acc_empty_q;
   logic [W-1:0] acc_best;
   logic [W-1:0] out_data_q;
   logic         out_valid_q;

   assign tail      = tree_q[NT-1];
   assign tail_vld  = vld_q[L-1];
   assign tail_lst  = lst_q[L-1];
   assign tail_mode = mod_q[L-1];

   // The accumulator is the left operand, so the earlier beat wins a tie.
   always_comb begin
      acc_best = tail;
      if (!acc_empty_q &&
          keep_left(acc_q[DATA_WIDTH-1:0], tail[DATA_WIDTH-1:0], tail_mode)) begin
         acc_best = acc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         acc_empty_q <= 1'b1;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (tail_vld) begin
            acc_q <= acc_best;
            if (tail_lst) begin
               out_data_q  <= acc_best;
               out_valid_q <= 1'b1;
               acc_empty_q <= 1'b1;
            end else begin
               acc_empty_q <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_argmax_tree_stream.sv
// -----------------------------------------------------------------------------
// tb_argmax_tree_stream
//
// Directed bench for argmax_tree_stream (N_INPUTS = 64, 7-cycle latency).
// A frame-level model scans every lane of every beat in arrival order and
// keeps the first strictly better score. That is the plain definition of an
// earliest-wins arg-max / arg-min. Each completed frame pushes its winner and
// its due cycle into exp_q / exp_t_q. A negedge compare process checks
// out_valid timing, out_data, data stability and frame_open against that
// model. Each directed test also checks its hand-computed winner.
// -----------------------------------------------------------------------------
module tb_argmax_tree_stream;
   localparam int DW  = 16;
   localparam int IW  = 13;
   localparam int AW  = 6;
   localparam int N   = 64;
   localparam int W   = DW + IW + AW;
   localparam int LAT = 7;   // cycles from last beat presented to out_valid

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   argmax_tree_stream_if #(.DATA_WIDTH(DW), .INDX_WIDTH(IW), .ADDR_WIDTH(AW), .N_INPUTS(N)) bus ();

   argmax_tree_stream #(.DATA_WIDTH(DW), .INDX_WIDTH(IW), .ADDR_WIDTH(AW), .N_INPUTS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // rising edges seen; stable when read at negedge
   int n_pulse = 0;

   logic [N*W-1:0] vec;
   int last_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [DW-1:0] s, input logic [IW-1:0] idx,
                                       input logic [AW-1:0] a);
      mk = {a, idx, s};
   endfunction

   // ---------------- model + scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           exp_t_q[$];
   logic         m_open;
   logic         m_mode;
   logic         m_have;
   logic [W-1:0] m_best;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_open = 1'b0;
         m_mode = 1'b0;
         m_have = 1'b0;
         exp_q.delete();
         exp_t_q.delete();
      end else if (bus.in_valid) begin
         if (!m_open) begin
            m_mode = bus.find_min;
         end
         for (int k = 0; k < N; k++) begin
            logic [W-1:0] w;
            w = bus.din[k*W +: W];
            if (!m_have ||
                (m_mode ? (w[DW-1:0] < m_best[DW-1:0]) : (w[DW-1:0] > m_best[DW-1:0]))) begin
               m_best = w;
               m_have = 1'b1;
            end
         end
         if (bus.in_last) begin
            exp_q.push_back(m_best);
            exp_t_q.push_back((cyc - 1) + LAT);   // beat was presented in cycle cyc-1
            m_have = 1'b0;
            m_open = 1'b0;
         end else begin
            m_open = 1'b1;
         end
      end
   end

   logic [W-1:0] prev_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_data = '0;
      end else begin
         if (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
            chk("missed_out_valid", 64'(bus.out_valid), 64'd1);
            void'(exp_q.pop_front());
            void'(exp_t_q.pop_front());
         end
         if (bus.out_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
               chk("result_cycle", 64'(cyc), 64'(exp_t_q.pop_front()));
               chk("result_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
         end else begin
            chk("out_data_hold", 64'(bus.out_data), 64'(prev_data));
         end
         chk("frame_open", 64'(bus.frame_open), 64'(m_open));
         prev_data = bus.out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill_all(input logic [DW-1:0] s, input int idx_base);
      for (int k = 0; k < N; k++) begin
         vec[k*W +: W] = mk(s, IW'(idx_base + k), AW'(k));
      end
   endtask

   task automatic set_lane(input int k, input logic [DW-1:0] s, input int idx);
      vec[k*W +: W] = mk(s, IW'(idx), AW'(k));
   endtask

   task automatic beat(input logic last, input logic fm);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      bus.find_min = fm;
      bus.din      = vec;
      last_t       = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         bus.find_min = $urandom_range(0, 1);
      end
   endtask

   // Bounded wait for the next pulse; checks the literal winner and due cycle.
   task automatic wait_result(input string name, input logic [W-1:0] exp_w, input int t_last);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 30);
      if (!bus.out_valid) begin
         chk({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk(name, 64'(bus.out_data), 64'(exp_w));
         chk({name, "_latency"}, 64'(cyc - t_last), 64'(LAT));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t_a;
      int t_b;
      int p0;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.find_min = 1'b0;
      bus.din      = '0;
      vec          = '0;

      repeat (3) @(negedge clk);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_data", 64'(bus.out_data), 64'd0);
      chk("reset_frame_open", 64'(bus.frame_open), 64'd0);
      rst_n = 1'b1;
      idle(2);

      // Single-beat max: lane 37 stands out.
      fill_all(16'h1234, 0);
      set_lane(37, 16'h8000, 37);
      beat(1'b1, 1'b0);
      t_a = last_t;
      idle(1);
      wait_result("single_max", mk(16'h8000, 13'd37, 6'd37), t_a);

      // Min mode with a tie between lanes 5 and 60: lower lane wins.
      fill_all(16'hFFFF, 0);
      set_lane(5, 16'h0003, 5);
      set_lane(60, 16'h0003, 60);
      beat(1'b1, 1'b1);
      t_a = last_t;
      idle(1);
      wait_result("min_tie", mk(16'h0003, 13'd5, 6'd5), t_a);

      // All lanes equal in max mode: lane 0 wins.
      fill_all(16'h0007, 0);
      beat(1'b1, 1'b0);
      t_a = last_t;
      idle(1);
      wait_result("all_equal_max", mk(16'h0007, 13'd0, 6'd0), t_a);
      idle(3);

      // 8 beats, max at beat 6 lane 2, bubbles after beat 3, find_min toggling.
      p0 = n_pulse;
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < N; k++) begin
            set_lane(k, DW'(((b * 7 + k * 3) % 200) + 1), b * 64 + k);
         end
         if (b == 6) set_lane(2, 16'hFFF0, 6 * 64 + 2);
         beat(b == 7, (b % 2) == 1);
         if (b == 3) idle(2);
      end
      t_a = last_t;
      idle(1);
      wait_result("multi_beat_max", mk(16'hFFF0, 13'(6 * 64 + 2), 6'd2), t_a);
      idle(10);
      chk("multi_beat_pulses", 64'(n_pulse - p0), 64'd1);

      // Cross-beat tie: beats 1 and 4 both hold 0xFFF0; beat 1 wins.
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < N; k++) begin
            set_lane(k, DW'((b * 13 + k) % 256), b * 64 + k);
         end
         if (b == 1) set_lane(10, 16'hFFF0, 64 + 10);
         if (b == 4) set_lane(3, 16'hFFF0, 4 * 64 + 3);
         beat(b == 4, 1'b0);
      end
      t_a = last_t;
      idle(1);
      wait_result("cross_beat_tie", mk(16'hFFF0, 13'(64 + 10), 6'd10), t_a);

      // Multi-beat min: mode taken from the first beat only.
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < N; k++) begin
            set_lane(k, DW'(16'h0010 + ((b * 5 + k) % 100)), b * 64 + k);
         end
         if (b == 2) set_lane(40, 16'h0001, 128 + 40);
         beat(b == 2, b == 0);
      end
      t_a = last_t;
      idle(1);
      wait_result("multi_beat_min", mk(16'h0001, 13'(128 + 40), 6'd40), t_a);
      idle(3);

      // Back-to-back: frame A (2 beats) then frame B (1 beat) with no gap.
      fill_all(16'h0010, 0);
      beat(1'b0, 1'b0);
      fill_all(16'h0010, 64);
      set_lane(9, 16'h0100, 64 + 9);
      beat(1'b1, 1'b0);
      t_a = last_t;
      fill_all(16'h0020, 13'h1000);
      set_lane(50, 16'h0050, 13'h1000 + 50);
      beat(1'b1, 1'b1 ^ 1'b1);
      t_b = last_t;
      // Two single-beat frames right behind, with opposite modes.
      fill_all(16'h0001, 0);
      set_lane(63, 16'h0009, 63);
      beat(1'b1, 1'b0);
      fill_all(16'h0002, 0);
      set_lane(1, 16'h0001, 1);
      beat(1'b1, 1'b1);
      idle(1);
      wait_result("b2b_frame_a", mk(16'h0100, 13'(64 + 9), 6'd9), t_a);
      wait_result("b2b_frame_b", mk(16'h0050, 13'(13'h1000 + 50), 6'd50), t_b);
      wait_result("single_c", mk(16'h0009, 13'd63, 6'd63), t_b + 1);
      wait_result("single_d_min", mk(16'h0001, 13'd1, 6'd1), t_b + 2);
      idle(3);

      // Reset mid-frame: partial frame is discarded.
      p0 = n_pulse;
      for (int b = 0; b < 3; b++) begin
         fill_all(16'hFFFF, b * 64);
         beat(1'b0, 1'b0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_frame_open", 64'(bus.frame_open), 64'd0);
      chk("midreset_out_data", 64'(bus.out_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fill_all(16'h0040, 0);
      set_lane(20, 16'h0041, 20);
      beat(1'b1, 1'b0);
      t_a = last_t;
      idle(1);
      wait_result("after_reset", mk(16'h0041, 13'd20, 6'd20), t_a);
      idle(12);
      chk("midreset_pulses", 64'(n_pulse - p0), 64'd1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
